// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle between a pipeline stage register and its neighbours.
// master drives the upstream fields and the forward select; slave is the register.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int NSLOT  = 5,
  parameter int SEL_W  = 3,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 8
);
  logic                    en;
  logic                    bubble;
  logic                    flush;
  logic [31:0]             in_pc;
  logic [31:0]             in_instr;
  logic                    in_valid;
  logic                    in_bd;
  logic [EXC_W-1:0]        in_exc;
  logic [NSLOT*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]        fwd_sel;

  logic [31:0]             out_pc;
  logic [31:0]             out_instr;
  logic                    out_valid;
  logic                    out_bd;
  logic [EXC_W-1:0]        out_exc;
  logic [NSLOT*DATA_W-1:0] out_data;
  logic [DATA_W-1:0]       fwd_val;
  logic                    fwd_ok;
  logic                    exc_pending;
  logic [CNT_W-1:0]        hold_cnt;

  modport master (
    output en, bubble, flush, in_pc, in_instr, in_valid, in_bd, in_exc, in_data, fwd_sel,
    input  out_pc, out_instr, out_valid, out_bd, out_exc, out_data,
           fwd_val, fwd_ok, exc_pending, hold_cnt
  );

  modport slave (
    input  en, bubble, flush, in_pc, in_instr, in_valid, in_bd, in_exc, in_data, fwd_sel,
    output out_pc, out_instr, out_valid, out_bd, out_exc, out_data,
           fwd_val, fwd_ok, exc_pending, hold_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage register: stall, bubble, flush-to-kernel,
// registered-source forward mux and a saturating stall counter.
module pipe_stage_reg #(
  parameter int          DATA_W    = 32,
  parameter int          NSLOT     = 5,
  parameter int          SEL_W     = 3,
  parameter logic [31:0] KERNEL_PC = 32'h0000_4180,
  parameter int          EXC_W     = 5,
  parameter int          CNT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  logic [31:0]             r_pc;
  logic [31:0]             r_instr;
  logic                    r_valid;
  logic                    r_bd;
  logic [EXC_W-1:0]        r_exc;
  logic [NSLOT*DATA_W-1:0] r_data;
  logic [CNT_W-1:0]        r_hold_cnt;

  logic [31:0]             w_pc8;
  logic [DATA_W-1:0]       w_fwd_val;
  logic                    w_fwd_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_bd       <= 1'b0;
      r_exc      <= '0;
      r_data     <= '0;
      r_hold_cnt <= '0;
    end else if (bus.flush) begin
      r_pc       <= KERNEL_PC;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_bd       <= 1'b0;
      r_exc      <= '0;
      r_data     <= '0;
      r_hold_cnt <= '0;
    end else if (bus.en) begin
      // A bubble keeps PC and BD so EPC/BD stay right for a later interrupt.
      r_pc       <= bus.in_pc;
      r_bd       <= bus.in_bd;
      r_hold_cnt <= '0;
      if (bus.bubble) begin
        r_instr <= '0;
        r_valid <= 1'b0;
        r_exc   <= '0;
        r_data  <= '0;
      end else begin
        r_instr <= bus.in_instr;
        r_valid <= bus.in_valid;
        r_exc   <= bus.in_exc;
        r_data  <= bus.in_data;
      end
    end else if (r_hold_cnt != '1) begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

  assign w_pc8 = r_pc + 32'd8;

  always_comb begin
    w_fwd_val = '0;
    w_fwd_ok  = 1'b0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (bus.fwd_sel == SEL_W'(k + 1)) begin
        w_fwd_val = r_data[k*DATA_W +: DATA_W];
        w_fwd_ok  = r_valid;
      end
    end
    if (bus.fwd_sel == SEL_W'(NSLOT + 1)) begin
      w_fwd_val = DATA_W'(w_pc8);
      w_fwd_ok  = r_valid;
    end
  end

  assign bus.out_pc      = r_pc;
  assign bus.out_instr   = r_instr;
  assign bus.out_valid   = r_valid;
  assign bus.out_bd      = r_bd;
  assign bus.out_exc     = r_exc;
  assign bus.out_data    = r_data;
  assign bus.fwd_val     = w_fwd_val;
  assign bus.fwd_ok      = w_fwd_ok;
  assign bus.exc_pending = r_valid && (r_exc != '0);
  assign bus.hold_cnt    = r_hold_cnt;

endmodule
